// File: rtl/smooth_datapath.sv
// smooth_datapath -- two-tap weighted smoothing datapath driven by an
// external controller.
//
// A sample is captured in IDLE (sample_valid), shifting the two-entry history
// (hist0 = x[n], hist1 = x[n-1]) and moving to BUSY. While BUSY the
// controller steers a multiply-accumulate with SClr / FactorSel / AddrSel and
// finishes the operation with OutEn, which emits either the scaled
// accumulator or, if no SClr happened since capture, the raw sample.
// A watchdog returns the block to IDLE if OutEn never arrives.
//
// Optional build macro: SMOOTH_SAT_EN -- saturate the scaled accumulator to
// 16 bits instead of wrapping.
//
// Ports:
//   sys_clk       clock, rising edge
//   reset         synchronous, active-high reset
//   sample_in     signed 16-bit input sample
//   sample_valid  sample_in valid this cycle
//   sample_rdy    block accepts a sample (IDLE)
//   ready         one-cycle pulse: new sample captured
//   FactorSel     coefficient select (0: COEF_A, 1: COEF_B); accumulate
//   SClr          clear accumulator and load current product
//   AddrSel       operand select (0: hist0, 1: hist1)
//   OutEn         emit result and return to IDLE
//   out_data      signed 16-bit result, held until next OutEn
//   out_valid     one-cycle pulse, out_data valid
//   proto_err     sticky protocol error (cleared by reset only)
module smooth_datapath #(
  parameter logic signed [7:0] COEF_A      = 8'sd64,
  parameter logic signed [7:0] COEF_B      = 8'sd64,
  parameter int                SHIFT       = 7,
  parameter int                WDOG_CYCLES = 16
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic               sample_rdy,
  output logic               ready,
  input  logic               FactorSel,
  input  logic               SClr,
  input  logic               AddrSel,
  input  logic               OutEn,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  output logic               proto_err
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic signed [15:0] hist0, hist1;
  logic signed [25:0] acc;
  logic               acc_valid;
  logic [WW-1:0]      wdog;

  logic signed [15:0] operand;
  logic signed [7:0]  coef;
  logic signed [23:0] product;
  logic signed [25:0] product_ext;
  logic signed [25:0] acc_sh;
  logic signed [15:0] fmt;
  logic               wdog_hit;

  // ---------------- datapath arithmetic ----------------
  always_comb begin
    operand     = AddrSel ? hist1 : hist0;
    coef        = FactorSel ? COEF_B : COEF_A;
    product     = operand * coef;
    product_ext = {{2{product[23]}}, product};
    acc_sh      = acc >>> SHIFT;
`ifdef SMOOTH_SAT_EN
    if (acc_sh > 26'sd32767)
      fmt = 16'sh7fff;
    else if (acc_sh < -26'sd32768)
      fmt = 16'sh8000;
    else
      fmt = acc_sh[15:0];
`else
    fmt = acc_sh[15:0];
`endif
  end

  // wdog counts completed BUSY cycles; the last allowed cycle times out.
  assign wdog_hit = (wdog == WW'(WDOG_CYCLES - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sample_valid)        state_nxt = BUSY;
      BUSY: if (OutEn || wdog_hit)   state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sample_rdy = (state == IDLE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hist0     <= '0;
      hist1     <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      wdog      <= '0;
      ready     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      proto_err <= 1'b0;
    end else begin
      ready     <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Controller strobes outside an operation are flagged only.
          if (SClr || FactorSel || OutEn) proto_err <= 1'b1;
          if (sample_valid) begin
            hist1     <= hist0;
            hist0     <= sample_in;
            acc_valid <= 1'b0;
            ready     <= 1'b1;
            wdog      <= '0;
          end
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          // OutEn wins over any accumulator update in the same cycle.
          if (OutEn) begin
            out_data  <= acc_valid ? fmt : hist0;
            out_valid <= 1'b1;
            acc_valid <= 1'b0;
          end else if (wdog_hit) begin
            proto_err <= 1'b1;
            acc_valid <= 1'b0;
          end else if (SClr) begin
            acc       <= product_ext;
            acc_valid <= 1'b1;
          end else if (FactorSel) begin
            acc <= acc + product_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smooth_datapath.sv
module tb_smooth_datapath;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               sample_valid, FactorSel, SClr, AddrSel, OutEn;

  // dut_a: default coefficients (64/64); dut_b: 127/127. Shared stimulus.
  logic               rdy_a, ready_a, ov_a, pe_a;
  logic signed [15:0] od_a;
  logic               rdy_b, ready_b, ov_b, pe_b;
  logic signed [15:0] od_b;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: history, per-DUT accumulator as plain integers.
  int     m_h0, m_h1;
  longint acc_a, acc_b;
  bit     m_av;
  logic signed [15:0] m_out_a, m_out_b;

  smooth_datapath dut_a (
    .sys_clk(sys_clk), .reset(reset), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_rdy(rdy_a), .ready(ready_a),
    .FactorSel(FactorSel), .SClr(SClr), .AddrSel(AddrSel), .OutEn(OutEn),
    .out_data(od_a), .out_valid(ov_a), .proto_err(pe_a));

  smooth_datapath #(.COEF_A(8'sd127), .COEF_B(8'sd127)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_rdy(rdy_b), .ready(ready_b),
    .FactorSel(FactorSel), .SClr(SClr), .AddrSel(AddrSel), .OutEn(OutEn),
    .out_data(od_b), .out_valid(ov_b), .proto_err(pe_b));

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Keep a value in the 26-bit two's-complement accumulator range.
  function automatic longint w26(longint v);
    return (v <<< 38) >>> 38;
  endfunction

  // Scale by 2^-7 and narrow to 16 bits.
  function automatic logic signed [15:0] fmt(longint a);
    longint s;
    logic [63:0] u;
    s = a >>> 7;
`ifdef SMOOTH_SAT_EN
    if (s > 32767)  return 16'sh7fff;
    if (s < -32768) return 16'sh8000;
`endif
    u = s;
    return $signed(u[15:0]);
  endfunction

  task automatic cyc;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs;
    sample_in = '0; sample_valid = 0; FactorSel = 0; SClr = 0; AddrSel = 0; OutEn = 0;
  endtask

  task automatic model_reset;
    m_h0 = 0; m_h1 = 0; acc_a = 0; acc_b = 0; m_av = 0; m_out_a = '0; m_out_b = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1; cyc(); cyc(); reset = 0;
    model_reset();
  endtask

  task automatic capture(input int s);
    sample_in = 16'(s); sample_valid = 1; cyc(); sample_valid = 0;
    m_h1 = m_h0; m_h0 = s; m_av = 0;
    checks++;
    if (ready_a !== 1'b1 || rdy_a !== 1'b0 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL capture: ready=%b/%b sample_rdy=%b, required ready=1 sample_rdy=0", ready_a, ready_b, rdy_a);
    end
  endtask

  // One BUSY control cycle; optional ignored sample_valid noise.
  task automatic op(input bit sclr, input bit fs, input bit addr, input bit noise);
    int opnd;
    SClr = sclr; FactorSel = fs; AddrSel = addr;
    sample_valid = noise; sample_in = 16'($urandom);
    cyc();
    SClr = 0; FactorSel = 0; AddrSel = 0; sample_valid = 0;
    opnd = addr ? m_h1 : m_h0;
    if (sclr) begin
      acc_a = opnd * 64; acc_b = opnd * 127; m_av = 1;
    end else if (fs) begin
      acc_a = w26(acc_a + opnd * 64); acc_b = w26(acc_b + opnd * 127);
    end
    checks++;
    if (ov_a !== 1'b0 || ready_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_op: out_valid=%b ready=%b sample_rdy=%b, required 0 0 0", ov_a, ready_a, rdy_a);
    end
  endtask

  // OutEn (with optional competing strobes) and the cycle after it.
  task automatic emit(input bit sclr_n, input bit fs_n);
    logic signed [15:0] ea, eb;
    OutEn = 1; SClr = sclr_n; FactorSel = fs_n;
    cyc();
    OutEn = 0; SClr = 0; FactorSel = 0;
    ea = m_av ? fmt(acc_a) : 16'(m_h0);
    eb = m_av ? fmt(acc_b) : 16'(m_h0);
    m_av = 0; m_out_a = ea; m_out_b = eb;
    checks++;
    if (ov_a !== 1'b1 || od_a !== ea || ov_b !== 1'b1 || od_b !== eb) begin
      errors++;
      $display("FAIL emit: out_valid=%b/%b out_data=%0d/%0d, required 1/1 %0d/%0d", ov_a, ov_b, od_a, od_b, ea, eb);
    end
    cyc();
    checks++;
    if (ov_a !== 1'b0 || od_a !== ea || od_b !== eb || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL emit_hold: out_valid=%b out_data=%0d/%0d sample_rdy=%b, required 0 %0d/%0d 1", ov_a, od_a, od_b, rdy_a, ea, eb);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (rdy_a !== 1 || ready_a !== 0 || ov_a !== 0 || od_a !== 0 || pe_a !== 0 ||
        rdy_b !== 1 || od_b !== 0 || pe_b !== 0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b ready=%b ov=%b od=%0d pe=%b, required 1 0 0 0 0", rdy_a, ready_a, ov_a, od_a, pe_a);
    end
  endtask

  task automatic test_smoothing;
    capture(100); op(1, 0, 0, 0); op(0, 1, 0, 0); emit(0, 0);
    checks++;
    if (od_a !== 16'sd100) begin
      errors++; $display("FAIL smooth_100: out_data=%0d, required 100", od_a);
    end
    capture(200); op(1, 0, 0, 0); op(0, 1, 1, 0); emit(0, 0);
    checks++;
    if (od_a !== 16'sd150) begin
      errors++; $display("FAIL smooth_150: out_data=%0d, required 150", od_a);
    end
  endtask

  task automatic test_raw;
    capture(500); emit(0, 0);
    checks++;
    if (od_a !== 16'sd500 || od_b !== 16'sd500) begin
      errors++; $display("FAIL raw_500: out_data=%0d/%0d, required 500", od_a, od_b);
    end
  endtask

  task automatic test_saturation;
    logic signed [15:0] want;
`ifdef SMOOTH_SAT_EN
    want = 16'sd32767;
`else
    want = -16'sd514;
`endif
    capture(32767); emit(0, 0);
    capture(32767); op(1, 0, 0, 0); op(0, 1, 1, 0); emit(0, 0);
    checks++;
    if (od_b !== want) begin
      errors++; $display("FAIL sat_wrap: out_data=%0d, required %0d", od_b, want);
    end
  endtask

  task automatic test_random;
    int n;
    for (int t = 0; t < 40; t++) begin
      capture(int'($urandom_range(0, 65535)) - 32768);
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++)
        op($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      emit($urandom_range(0, 1), $urandom_range(0, 1));
    end
  endtask

  task automatic test_idle_err;
    checks++;
    if (pe_a !== 1'b0) begin
      errors++; $display("FAIL err_clean: proto_err=%b, required 0", pe_a);
    end
    OutEn = 1; cyc(); OutEn = 0;
    checks++;
    if (pe_a !== 1'b1 || ov_a !== 1'b0 || od_a !== m_out_a || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL idle_outen: proto_err=%b ov=%b od=%0d rdy=%b, required 1 0 %0d 1", pe_a, ov_a, od_a, rdy_a, m_out_a);
    end
    cyc();
    checks++;
    if (pe_a !== 1'b1 || ov_a !== 1'b0) begin
      errors++; $display("FAIL err_sticky: proto_err=%b ov=%b, required 1 0", pe_a, ov_a);
    end
  endtask

  task automatic test_watchdog;
    do_reset();
    capture(int'($urandom_range(0, 1000)));
    for (int k = 1; k < 16; k++) begin
      cyc();
      checks++;
      if (rdy_a !== 1'b0 || ov_a !== 1'b0 || pe_a !== 1'b0) begin
        errors++;
        $display("FAIL wdog_busy: cycle %0d rdy=%b ov=%b pe=%b, required 0 0 0", k, rdy_a, ov_a, pe_a);
      end
    end
    cyc();
    m_av = 0;
    checks++;
    if (rdy_a !== 1'b1 || ov_a !== 1'b0 || pe_a !== 1'b1 || od_a !== 16'sd0) begin
      errors++;
      $display("FAIL wdog_expire: rdy=%b ov=%b pe=%b od=%0d, required 1 0 1 0", rdy_a, ov_a, pe_a, od_a);
    end
    // Block must be usable after a timeout.
    capture(-1234); emit(0, 0);
  endtask

  task automatic test_reset_mid;
    do_reset();
    capture(300); op(1, 0, 0, 0);
    reset = 1; cyc(); reset = 0;
    model_reset();
    checks++;
    if (rdy_a !== 1 || ready_a !== 0 || ov_a !== 0 || od_a !== 0 || pe_a !== 0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b ready=%b ov=%b od=%0d pe=%b, required 1 0 0 0 0", rdy_a, ready_a, ov_a, od_a, pe_a);
    end
    cyc();
    checks++;
    if (ov_a !== 1'b0) begin
      errors++; $display("FAIL reset_mid_nov: out_valid=%b, required 0", ov_a);
    end
    capture(1000); op(1, 0, 1, 0); op(0, 1, 0, 0); emit(0, 0);
    checks++;
    if (od_a !== 16'sd500) begin
      errors++; $display("FAIL reset_hist1: out_data=%0d, required 500", od_a);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_smoothing();
    test_raw();
    test_saturation();
    test_random();
    test_idle_err();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
